// File: rtl/multer_arbiter_pkg.sv
// Shared definitions for the multer arbiter: FSM state encoding and width helpers.
package multer_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_ACK   = 2'd2,
    ST_WAIT  = 2'd3
  } state_e;

  localparam int DEF_N = 2;
  localparam int DEF_W = 8;

  function automatic int prod_width(input int w);
    return 2 * w;
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/multer_arbiter_if.sv
// Bundle of requester-side and multer-side signals around the shared multiplier arbiter.
interface multer_arbiter_if #(
  parameter int N = 2,
  parameter int W = 8
);
  import multer_arbiter_pkg::*;

  localparam int YW = prod_width(W);

  logic [N-1:0]   start_i;
  logic [N*W-1:0] a_bi;
  logic [N*W-1:0] b_bi;
  logic [N-1:0]   busy_o;
  logic [N-1:0]   done_o;
  logic [YW-1:0]  y_bo;
  logic [W-1:0]   mul_a_bo;
  logic [W-1:0]   mul_b_bo;
  logic           mul_start_o;
  logic           mul_busy_i;
  logic [YW-1:0]  mul_y_bi;

  modport slave (
    input  start_i, a_bi, b_bi, mul_busy_i, mul_y_bi,
    output busy_o, done_o, y_bo, mul_a_bo, mul_b_bo, mul_start_o
  );

  modport master (
    output start_i, a_bi, b_bi, mul_busy_i, mul_y_bi,
    input  busy_o, done_o, y_bo, mul_a_bo, mul_b_bo, mul_start_o
  );

endinterface

// File: rtl/multer_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: first pending bit strictly after the pointer, wrapping.
module multer_arbiter_rr_pick #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  pending_i,
  input  logic [IW-1:0] ptr_i,
  output logic          any_o,
  output logic [IW-1:0] grant_o
);

  logic [IW-1:0] idx;

  // Scan from the farthest candidate down so the nearest one after the pointer wins.
  always_comb begin
    any_o   = 1'b0;
    grant_o = '0;
    idx     = '0;
    for (int k = N; k >= 1; k--) begin
      idx = IW'((int'(ptr_i) + k) % N);
      if (pending_i[idx]) begin
        any_o   = 1'b1;
        grant_o = idx;
      end
    end
  end

endmodule

// File: rtl/multer_arbiter.sv
// Shares one 8x8 multiplier between N requesters; each port sees a private start/busy/done multiplier.
module multer_arbiter
  import multer_arbiter_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int W = DEF_W
) (
  input  logic clk_i,
  input  logic rst_i,
  multer_arbiter_if.slave bus
);

  localparam int IW = idx_width(N);
  localparam int YW = prod_width(W);

  state_e         state_q, state_d;
  logic [N-1:0]   pending_q, pending_d;
  logic [IW-1:0]  grant_q, grant_d;
  logic [IW-1:0]  ptr_q, ptr_d;
  logic [N*W-1:0] opa_q, opa_d;
  logic [N*W-1:0] opb_q, opb_d;
  logic [W-1:0]   mul_a_q, mul_a_d;
  logic [W-1:0]   mul_b_q, mul_b_d;
  logic [YW-1:0]  y_q, y_d;
  logic [N-1:0]   done_q, done_d;

  logic [N-1:0]   busy;
  logic [N-1:0]   capture;
  logic           pick_any;
  logic [IW-1:0]  pick_grant;

  multer_arbiter_rr_pick #(
    .N  (N),
    .IW (IW)
  ) u_rr_pick (
    .pending_i (pending_q),
    .ptr_i     (ptr_q),
    .any_o     (pick_any),
    .grant_o   (pick_grant)
  );

  // A granted port stays busy until its done cycle, even though its pending bit is already clear.
  always_comb begin
    busy = '0;
    for (int i = 0; i < N; i++) begin
      busy[i] = pending_q[i] | ((state_q != ST_IDLE) && (grant_q == IW'(i)));
    end
    capture = bus.start_i & ~busy;
  end

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    mul_a_d   = mul_a_q;
    mul_b_d   = mul_b_q;
    y_d       = y_q;
    done_d    = '0;

    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          grant_d               = pick_grant;
          pending_d[pick_grant] = 1'b0;
          mul_a_d               = opa_q[int'(pick_grant)*W +: W];
          mul_b_d               = opb_q[int'(pick_grant)*W +: W];
          state_d               = ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_ACK;
      // The multer only raises busy after seeing start, so busy is not trusted until WAIT.
      ST_ACK:   state_d = ST_WAIT;
      ST_WAIT: begin
        if (!bus.mul_busy_i) begin
          y_d             = bus.mul_y_bi;
          done_d[grant_q] = 1'b1;
          ptr_d           = grant_q;
          state_d         = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    for (int i = 0; i < N; i++) begin
      if (capture[i]) begin
        pending_d[i]      = 1'b1;
        opa_d[i*W +: W]   = bus.a_bi[i*W +: W];
        opb_d[i*W +: W]   = bus.b_bi[i*W +: W];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= ST_IDLE;
      pending_q <= '0;
      grant_q   <= '0;
      ptr_q     <= IW'(N - 1);
      opa_q     <= '0;
      opb_q     <= '0;
      mul_a_q   <= '0;
      mul_b_q   <= '0;
      y_q       <= '0;
      done_q    <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      grant_q   <= grant_d;
      ptr_q     <= ptr_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      mul_a_q   <= mul_a_d;
      mul_b_q   <= mul_b_d;
      y_q       <= y_d;
      done_q    <= done_d;
    end
  end

  assign bus.busy_o      = busy;
  assign bus.done_o      = done_q;
  assign bus.y_bo        = y_q;
  assign bus.mul_a_bo    = mul_a_q;
  assign bus.mul_b_bo    = mul_b_q;
  assign bus.mul_start_o = (state_q == ST_ISSUE);

endmodule

// File: tb/tb_multer_arbiter.sv
// Self-checking bench for multer_arbiter: directed scenarios plus random traffic against a scoreboard model.
module tb_multer_arbiter;

  localparam int N   = 3;
  localparam int W   = 8;
  localparam int TIW = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  multer_arbiter_if #(.N(N), .W(W)) bif ();

  multer_arbiter #(.N(N), .W(W)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bif)
  );

  // Behavioural multiplier: busy for mul_lat_cfg cycles after start, product appears as busy drops.
  logic        m_busy;
  logic [15:0] m_y;
  logic [7:0]  m_a, m_b;
  int          m_cnt;
  int          mul_lat_cfg = 3;

  assign bif.mul_busy_i = m_busy;
  assign bif.mul_y_bi   = m_y;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_cnt  <= 0;
      m_y    <= '0;
      m_a    <= '0;
      m_b    <= '0;
    end else if (bif.mul_start_o) begin
      m_busy <= 1'b1;
      m_cnt  <= mul_lat_cfg;
      m_a    <= bif.mul_a_bo;
      m_b    <= bif.mul_b_bo;
    end else if (m_busy) begin
      if (m_cnt == 1) begin
        m_busy <= 1'b0;
        m_y    <= 16'(m_a) * 16'(m_b);
      end
      m_cnt <= m_cnt - 1;
    end
  end

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  int         checks = 0;
  int         errors = 0;
  bit         out_m     [N];
  bit         granted_m [N];
  int         req_edge  [N];
  logic [7:0] req_a     [N];
  logic [7:0] req_b     [N];
  int         done_edge [N];
  int         done_cnt  [N];
  int         last_ptr  = N - 1;
  int         cur_grant = -1;
  int         start_cnt = 0;
  int         acc_cnt   = 0;
  int         grant_log [$];
  int         y_log     [$];
  logic [N-1:0] done_seen;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d, required %0d", tag, obs, want);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < N; i++) begin
      out_m[i]     = 1'b0;
      granted_m[i] = 1'b0;
    end
    last_ptr  = N - 1;
    cur_grant = -1;
  endtask

  function automatic bit anyOut();
    bit r = 1'b0;
    for (int i = 0; i < N; i++) r |= out_m[i];
    return r;
  endfunction

  function automatic int totalDone();
    int s = 0;
    for (int i = 0; i < N; i++) s += done_cnt[i];
    return s;
  endfunction

  // Called at each falling edge: checks the issued request and any completion against the model.
  task automatic observe();
    done_seen = bif.done_o;
    if (bif.mul_start_o === 1'b1) begin
      int g;
      g = -1;
      start_cnt++;
      for (int k = 1; k <= N; k++) begin
        int p;
        p = (last_ptr + k) % N;
        if (g < 0 && out_m[p] && !granted_m[p] && req_edge[p] <= edge_cnt - 1) g = p;
      end
      if (g < 0) begin
        checkOutput("unexpected_issue", 32'(bif.mul_start_o), 32'd0);
      end else begin
        checkOutput("issue_a", 32'(bif.mul_a_bo), 32'(req_a[g]));
        checkOutput("issue_b", 32'(bif.mul_b_bo), 32'(req_b[g]));
        granted_m[g] = 1'b1;
        cur_grant    = g;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (bif.done_o[TIW'(i)] === 1'b1) begin
        checkOutput("done_expected", 32'(out_m[i]), 32'd1);
        checkOutput("done_port", i, cur_grant);
        checkOutput("done_y", 32'(bif.y_bo), 32'(req_a[i]) * 32'(req_b[i]));
        out_m[i]     = 1'b0;
        granted_m[i] = 1'b0;
        last_ptr     = i;
        cur_grant    = -1;
        done_cnt[i]++;
        done_edge[i] = edge_cnt;
        grant_log.push_back(i);
        y_log.push_back(int'(bif.y_bo));
      end
    end
    for (int i = 0; i < N; i++) begin
      checkOutput("busy", 32'(bif.busy_o[TIW'(i)]), 32'(out_m[i]));
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    bif.start_i = '0;
    observe();
  endtask

  task automatic applyStimulus(input int port, input logic [7:0] a, input logic [7:0] b);
    bif.start_i = bif.start_i | (N'(1) << port);
    bif.a_bi[port*W +: W] = a;
    bif.b_bi[port*W +: W] = b;
    if (!out_m[port] && rst_n) begin
      out_m[port]     = 1'b1;
      granted_m[port] = 1'b0;
      req_a[port]     = a;
      req_b[port]     = b;
      req_edge[port]  = edge_cnt + 1;
      acc_cnt++;
    end
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    modelReset();
    cycle();
    cycle();
    rst_n = 1'b1;
  endtask

  task automatic waitIdle(input int budget);
    int k = 0;
    while (anyOut() && k < budget) begin
      cycle();
      k++;
    end
    checkOutput("drain", 32'(anyOut()), 32'd0);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_busy"},  32'(bif.busy_o),      32'd0);
    checkOutput({tag, "_done"},  32'(bif.done_o),      32'd0);
    checkOutput({tag, "_y"},     32'(bif.y_bo),        32'd0);
    checkOutput({tag, "_mul_a"}, 32'(bif.mul_a_bo),    32'd0);
    checkOutput({tag, "_mul_b"}, 32'(bif.mul_b_bo),    32'd0);
    checkOutput({tag, "_start"}, 32'(bif.mul_start_o), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int s0, d0, d1, re, lg, k, acc0, dsum0;
    bif.start_i = '0;
    bif.a_bi    = '0;
    bif.b_bi    = '0;
    for (int i = 0; i < N; i++) done_cnt[i] = 0;
    modelReset();

    // Reset state
    #2;
    checkAllZero("rst");
    cycle();
    cycle();
    rst_n = 1'b1;

    // Single port: 13*11, issue two cycles after the request
    $display("[TB] single port");
    mul_lat_cfg = 3;
    s0 = start_cnt;
    d0 = done_cnt[0];
    applyStimulus(0, 8'd13, 8'd11);
    re = req_edge[0];
    cycle();
    checkOutput("issue_cycle1", 32'(bif.mul_start_o), 32'd0);
    cycle();
    checkOutput("issue_cycle2", 32'(bif.mul_start_o), 32'd1);
    cycle();
    checkOutput("issue_pulse", 32'(bif.mul_start_o), 32'd0);
    waitIdle(40);
    checkOutput("single_y", 32'(bif.y_bo), 32'd143);
    checkOutput("single_dones", done_cnt[0] - d0, 32'd1);
    checkOutput("single_starts", start_cnt - s0, 32'd1);
    checkOutput("single_latency", done_edge[0] - (re - 1), 32'd7);

    // Contention from reset: port 0 first
    $display("[TB] contention");
    doReset();
    s0 = start_cnt;
    lg = grant_log.size();
    applyStimulus(0, 8'd255, 8'd255);
    applyStimulus(1, 8'd7, 8'd9);
    waitIdle(60);
    checkOutput("cont_count", grant_log.size() - lg, 32'd2);
    checkOutput("cont_first_port", grant_log[lg], 32'd0);
    checkOutput("cont_first_y", y_log[lg], 32'd65025);
    checkOutput("cont_second_port", grant_log[lg + 1], 32'd1);
    checkOutput("cont_second_y", y_log[lg + 1], 32'd63);
    checkOutput("cont_starts", start_cnt - s0, 32'd2);

    // Fairness: both ports re-request on every done
    $display("[TB] fairness");
    doReset();
    mul_lat_cfg = 2;
    lg = grant_log.size();
    applyStimulus(0, 8'($urandom), 8'($urandom));
    applyStimulus(1, 8'($urandom), 8'($urandom));
    k = 0;
    while (grant_log.size() - lg < 6 && k < 300) begin
      cycle();
      k++;
      for (int i = 0; i < 2; i++) begin
        if (done_seen[TIW'(i)] && grant_log.size() - lg < 6)
          applyStimulus(i, 8'($urandom), 8'($urandom));
      end
    end
    waitIdle(60);
    checkOutput("fair_count", grant_log.size() - lg, 32'd7);
    for (int j = 0; j < 6; j++) checkOutput("fair_order", grant_log[lg + j], j % 2);

    // Ignored start while busy
    $display("[TB] ignored start");
    doReset();
    mul_lat_cfg = 4;
    d1 = done_cnt[1];
    applyStimulus(1, 8'd20, 8'd30);
    cycle();
    applyStimulus(1, 8'd99, 8'd99);
    cycle();
    cycle();
    applyStimulus(1, 8'd50, 8'd50);
    waitIdle(40);
    repeat (15) cycle();
    checkOutput("ignored_dones", done_cnt[1] - d1, 32'd1);
    checkOutput("ignored_y", 32'(bif.y_bo), 32'd600);

    // Reset during WAIT with port 1 pending
    $display("[TB] reset mid-wait");
    doReset();
    mul_lat_cfg = 12;
    d1 = done_cnt[1];
    applyStimulus(0, 8'd5, 8'd5);
    applyStimulus(1, 8'd6, 8'd6);
    repeat (5) cycle();
    checkOutput("prewait_busy", 32'(bif.busy_o), 32'd3);
    #2;
    rst_n = 1'b0;
    modelReset();
    #1;
    checkAllZero("midrst");
    repeat (3) cycle();
    rst_n = 1'b1;
    s0 = start_cnt;
    d0 = done_cnt[0];
    mul_lat_cfg = 2;
    applyStimulus(0, 8'd2, 8'd3);
    waitIdle(40);
    repeat (10) cycle();
    checkOutput("after_rst_y", 32'(bif.y_bo), 32'd6);
    checkOutput("after_rst_dones0", done_cnt[0] - d0, 32'd1);
    checkOutput("after_rst_starts", start_cnt - s0, 32'd1);
    checkOutput("after_rst_dones1", done_cnt[1] - d1, 32'd0);

    // Zero operand
    $display("[TB] zero operand");
    d0 = done_cnt[0];
    applyStimulus(0, 8'd0, 8'd200);
    waitIdle(40);
    checkOutput("zero_y", 32'(bif.y_bo), 32'd0);
    checkOutput("zero_dones", done_cnt[0] - d0, 32'd1);

    // Random traffic on all ports with varying multiplier latency
    $display("[TB] random traffic");
    acc0  = acc_cnt;
    dsum0 = totalDone();
    for (int c = 0; c < 400; c++) begin
      mul_lat_cfg = $urandom_range(1, 5);
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 3) == 0) applyStimulus(i, 8'($urandom), 8'($urandom));
      end
      cycle();
    end
    waitIdle(100);
    repeat (5) cycle();
    checkOutput("random_completed", totalDone() - dsum0, acc_cnt - acc0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multer_arbiter.md
Name: multer_arbiter

Overview:
- Shares one `multer` instance (8x8 -> 16 unsigned) between N requesters, e.g. `cuberoot` and a sibling root/divider unit.
- Each requester port behaves like a private multiplier: start pulse in, busy level out, plus a done pulse.
- The arbiter queues pending requests, grants round-robin, sequences the multer start/busy handshake and returns the product to the granted requester.

Parameters:
- N, 2, number of requester ports (2..8).
- W, 8, operand width; product width is 2W.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- start_i  in  N  per-requester start; high for one cycle samples that port's operands.
- a_bi  in  N*W  operand A, port i at bits [i*W +: W].
- b_bi  in  N*W  operand B, same packing.
- busy_o  out  N  port i has a pending or in-flight operation.
- done_o  out  N  one-cycle pulse: result for port i is on y_bo.
- y_bo  out  2W  last product; holds until the next done.
- mul_a_bo  out  W  to multer a_bi.
- mul_b_bo  out  W  to multer b_bi.
- mul_start_o  out  1  to multer start_i.
- mul_busy_i  in  1  from multer busy_o.
- mul_y_bi  in  2W  from multer y_bo.

Behaviour:
- Reset (rst_i low, any time, including mid-operation):
  - busy_o, done_o, y_bo, mul_a_bo, mul_b_bo, mul_start_o all go to 0.
  - Pending bits and operand registers clear.
  - State goes to IDLE; round-robin pointer goes to N-1, so port 0 wins first.
  - An in-flight multer result is discarded.
- Request capture, per port i:
  - If start_i[i] is high and busy_o[i] is low, latch a_bi/b_bi slice i into that port's operand registers and set pending[i].
  - busy_o[i] is high from the next cycle.
  - start_i[i] while busy_o[i] is high is ignored: no queueing depth beyond 1 per port.
- busy_o[i] = pending[i] OR (state != IDLE AND grant == i). It drops in the same cycle done_o[i] rises.
- State machine:
  - IDLE: if any pending bit is set, pick the first set bit searching from pointer+1 upward, with wrap-around. Then:
    - grant <= g; pending[g] <= 0.
    - mul_a_bo/mul_b_bo <= port g operands.
    - Go to ISSUE.
  - ISSUE: mul_start_o = 1 for exactly one cycle; go to ACK.
  - ACK: mul_start_o = 0. This is a one-cycle guard so mul_busy_i is not sampled before the multer has raised it. Go to WAIT.
  - WAIT: when mul_busy_i is low, do the following at that edge, then return to IDLE:
    - y_bo <= mul_y_bi.
    - done_o[grant] <= 1 for one cycle.
    - pointer <= grant.
- Latency:
  - Request to issue: start_i at cycle 0 to mul_start_o high at cycle 2, if the arbiter is idle.
  - Total latency = 4 + multer busy length cycles.
  - Minimum spacing between consecutive grants is 4 cycles (IDLE, ISSUE, ACK, WAIT).
- Simultaneous events:
  - start_i on several ports in one cycle: all are captured; service order is round-robin.
  - start_i[i] in the same cycle as done_o[i]: accepted, because busy_o[i] is already low. Its grant waits behind other pending ports.
  - start_i on a non-granted port during WAIT: captured normally.
- Width rules: unsigned operands; y_bo is the full 2W product with no truncation.
- mul_a_bo/mul_b_bo hold their value from grant until the next grant.

Decomposition:
- Shared package: state encoding (IDLE=0, ISSUE=1, ACK=2, WAIT=3), and a localparam for product width 2W.
- Sub-module rr_pick: combinational round-robin priority encoder.
  - Inputs: pending[N], pointer.
  - Outputs: any, grant index.
  - Tested separately.
- multer stays outside and is connected at the top level.

Test Plan:
- Single port: port0 start with a=13, b=11 -> mul_start_o pulses once at cycle 2; done_o=01 and y_bo=143; busy_o[0] high throughout, then low in the done cycle.
- Contention: both ports start in the same cycle, a0=255 b0=255, a1=7 b1=9 -> port0 served first with y_bo=65025, then port1 with y_bo=63; exactly two mul_start_o pulses.
- Fairness: both ports re-issue start on every done for 6 operations -> grants strictly alternate 0,1,0,1,0,1.
- Ignored start: port1 pulses start again with different operands while busy_o[1]=1 -> only the first operands' product is returned; one done_o[1] only.
- Reset mid-WAIT: rst_i low during WAIT with port1 pending -> all outputs 0 and no done_o. After release, port0 start 2*3 -> y_bo=6, and port1 is not served because its pending bit was cleared.
- Zero operands: a=0, b=200 -> y_bo=0 and done_o pulses normally.
